// File: rtl/snake_step_sequencer.sv
// Snake game step sequencer: turns game ticks into datapath step requests and
// tracks score, pause, game-over and the speed (frame-wait) setting.
module snake_step_sequencer #(
  parameter int INIT_WAIT  = 4,
  parameter int MIN_WAIT   = 1,
  parameter int SPEED_STEP = 4
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_tick,
  input  logic       i_start,
  input  logic       i_pause,
  input  logic       i_dir_valid,
  input  logic [1:0] i_dir,
  input  logic       i_step_done,
  input  logic       i_collision,
  input  logic       i_food_hit,
  output logic       o_step_req,
  output logic [1:0] o_dir,
  output logic       o_grow,
  output logic [7:0] o_score,
  output logic [2:0] o_wait_cycles,
  output logic       o_running,
  output logic       o_paused,
  output logic       o_game_over,
  output logic       o_overrun
);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_RUN       = 3'd1;
  localparam logic [2:0] ST_STEP      = 3'd2;
  localparam logic [2:0] ST_WAIT_DONE = 3'd3;
  localparam logic [2:0] ST_PAUSED    = 3'd4;
  localparam logic [2:0] ST_OVER      = 3'd5;

  localparam int         SHIFT  = $clog2(SPEED_STEP);
  localparam logic [7:0] INIT_W = 8'(INIT_WAIT);
  localparam logic [7:0] MIN_W  = 8'(MIN_WAIT);
  localparam logic [7:0] SPAN_W = 8'(INIT_WAIT - MIN_WAIT);

  logic [2:0] state;
  logic [2:0] state_next;
  logic [1:0] dir_pending;
  logic       pause_pending;
  logic       start_ok;
  logic       in_flight;
  logic       done_ok;
  logic       dir_ok;
  logic       food_ok;
  logic [7:0] score_div;
  logic [7:0] wait_target;

  assign start_ok  = i_start && (state == ST_IDLE || state == ST_OVER);
  assign in_flight = (state == ST_STEP) || (state == ST_WAIT_DONE);
  assign done_ok   = i_step_done && (state == ST_WAIT_DONE);
  assign food_ok   = done_ok && !i_collision && i_food_hit;
  // A reversal is judged against the direction the snake is actually moving.
  assign dir_ok    = i_dir_valid && (state != ST_IDLE) && (state != ST_OVER)
                     && (i_dir != (o_dir ^ 2'd2));

  assign score_div   = o_score >> SHIFT;
  assign wait_target = (score_div >= SPAN_W) ? MIN_W : (INIT_W - score_div);

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE, ST_OVER: if (i_start) state_next = ST_RUN;
      ST_RUN: begin
        if (i_pause)     state_next = ST_PAUSED;
        else if (i_tick) state_next = ST_STEP;
      end
      ST_STEP:      state_next = ST_WAIT_DONE;
      // Collision outranks a deferred pause; a pause arriving with the ack still counts.
      ST_WAIT_DONE: begin
        if (i_step_done) begin
          if (i_collision)                   state_next = ST_OVER;
          else if (pause_pending || i_pause) state_next = ST_PAUSED;
          else                               state_next = ST_RUN;
        end
      end
      ST_PAUSED: if (i_pause) state_next = ST_RUN;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state         <= ST_IDLE;
      dir_pending   <= 2'd1;
      pause_pending <= 1'b0;
      o_step_req    <= 1'b0;
      o_dir         <= 2'd1;
      o_grow        <= 1'b0;
      o_score       <= 8'd0;
      o_wait_cycles <= INIT_W[2:0];
      o_running     <= 1'b0;
      o_paused      <= 1'b0;
      o_game_over   <= 1'b0;
      o_overrun     <= 1'b0;
    end else begin
      state       <= state_next;
      o_running   <= (state_next == ST_RUN) || (state_next == ST_STEP)
                     || (state_next == ST_WAIT_DONE);
      o_paused    <= (state_next == ST_PAUSED);
      o_game_over <= (state_next == ST_OVER);
      o_step_req  <= (state == ST_STEP);
      o_grow      <= food_ok;
      if (start_ok) begin
        o_score       <= 8'd0;
        o_overrun     <= 1'b0;
        pause_pending <= 1'b0;
        o_dir         <= 2'd1;
        dir_pending   <= 2'd1;
        o_wait_cycles <= INIT_W[2:0];
      end else begin
        o_wait_cycles <= wait_target[2:0];
        if (state == ST_RUN && i_tick && !i_pause) o_dir <= dir_pending;
        if (dir_ok) dir_pending <= i_dir;
        if (in_flight && i_tick) o_overrun <= 1'b1;
        if (food_ok && o_score != 8'hFF) o_score <= o_score + 8'd1;
        if (done_ok)                 pause_pending <= 1'b0;
        else if (in_flight && i_pause) pause_pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_snake_step_sequencer.sv
// Scoreboard bench for snake_step_sequencer: a transaction-level game model
// predicts step requests and grow pulses; a negedge monitor checks them.
module tb_snake_step_sequencer;

  localparam int INIT_WAIT  = 4;
  localparam int MIN_WAIT   = 1;
  localparam int SPEED_STEP = 4;

  logic       i_clock;
  logic       i_reset;
  logic       i_tick;
  logic       i_start;
  logic       i_pause;
  logic       i_dir_valid;
  logic [1:0] i_dir;
  logic       i_step_done;
  logic       i_collision;
  logic       i_food_hit;
  logic       o_step_req;
  logic [1:0] o_dir;
  logic       o_grow;
  logic [7:0] o_score;
  logic [2:0] o_wait_cycles;
  logic       o_running;
  logic       o_paused;
  logic       o_game_over;
  logic       o_overrun;

  snake_step_sequencer #(
    .INIT_WAIT(INIT_WAIT), .MIN_WAIT(MIN_WAIT), .SPEED_STEP(SPEED_STEP)
  ) dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_tick(i_tick), .i_start(i_start),
    .i_pause(i_pause), .i_dir_valid(i_dir_valid), .i_dir(i_dir),
    .i_step_done(i_step_done), .i_collision(i_collision), .i_food_hit(i_food_hit),
    .o_step_req(o_step_req), .o_dir(o_dir), .o_grow(o_grow), .o_score(o_score),
    .o_wait_cycles(o_wait_cycles), .o_running(o_running), .o_paused(o_paused),
    .o_game_over(o_game_over), .o_overrun(o_overrun)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  int cyc = 0;
  always @(posedge i_clock) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef enum int {M_IDLE, M_RUN, M_PAUSED, M_OVER} mode_t;
  typedef struct { logic [1:0] dir; int cyc; } step_t;
  typedef struct { int score; int cyc; } grow_t;

  mode_t      m_mode;
  logic [1:0] m_dir;
  logic [1:0] m_pend;
  int         m_score;
  bit         m_overrun;
  bit         m_pause_pend;
  bit         rand_dirs;
  step_t      step_q[$];
  grow_t      grow_q[$];
  step_t      mon_s;
  grow_t      mon_g;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic int exp_wait();
    int w;
    w = INIT_WAIT - m_score / SPEED_STEP;
    return (w < MIN_WAIT) ? MIN_WAIT : w;
  endfunction

  function automatic void model_reset();
    m_mode = M_IDLE;
    m_dir = 2'd1;
    m_pend = 2'd1;
    m_score = 0;
    m_overrun = 1'b0;
    m_pause_pend = 1'b0;
  endfunction

  // One cycle of inputs; optionally sprinkles a random direction request.
  task automatic apply_stimulus(input bit tick, input bit start, input bit pause,
                                input bit done, input bit coll, input bit food,
                                input bit dv = 1'b0, input logic [1:0] d = 2'd0);
    bit         use_dv;
    logic [1:0] dd;
    @(posedge i_clock);
    #1;
    use_dv = dv;
    dd = d;
    if (!dv && rand_dirs && !tick && !start && $urandom_range(0, 2) == 0) begin
      use_dv = 1'b1;
      dd = 2'($urandom_range(0, 3));
    end
    if (use_dv && m_mode != M_IDLE && m_mode != M_OVER && dd != (m_dir ^ 2'd2))
      m_pend = dd;
    i_tick = tick;
    i_start = start;
    i_pause = pause;
    i_step_done = done;
    i_collision = coll;
    i_food_hit = food;
    i_dir_valid = use_dv;
    i_dir = dd;
  endtask

  task automatic idle(input int n);
    repeat (n) apply_stimulus(0, 0, 0, 0, 0, 0);
  endtask

  task automatic start_game();
    apply_stimulus(0, 1, 0, 0, 0, 0);
    model_reset();
    m_mode = M_RUN;
  endtask

  task automatic do_step(input bit food, input bit coll, input bit pause_mid,
                         input bit tick_mid, input bit tick_done, input int delay);
    bit p;
    bit t;
    apply_stimulus(1, 0, 0, 0, 0, 0);
    step_q.push_back('{m_pend, cyc + 2});
    m_dir = m_pend;
    apply_stimulus(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < delay; i++) begin
      p = pause_mid && (i == 0);
      t = tick_mid && (i == delay - 1);
      apply_stimulus(t, 0, p, 0, 0, 0);
      if (p) m_pause_pend = 1'b1;
      if (t) m_overrun = 1'b1;
    end
    apply_stimulus(tick_done, 0, 0, 1, coll, food);
    if (tick_done) m_overrun = 1'b1;
    if (coll) begin
      m_mode = M_OVER;
    end else begin
      if (food) begin
        if (m_score < 255) m_score++;
        grow_q.push_back('{m_score, cyc + 1});
      end
      m_mode = m_pause_pend ? M_PAUSED : M_RUN;
    end
    m_pause_pend = 1'b0;
  endtask

  task automatic toggle_pause(input bit with_tick);
    apply_stimulus(with_tick, 0, 1, 0, 0, 0);
    if (m_mode == M_RUN)         m_mode = M_PAUSED;
    else if (m_mode == M_PAUSED) m_mode = M_RUN;
  endtask

  task automatic check_output(input string tag);
    idle(2);
    @(negedge i_clock);
    check({tag, "_score"}, o_score, m_score);
    check({tag, "_wait"}, o_wait_cycles, exp_wait());
    check({tag, "_dir"}, o_dir, m_dir);
    check({tag, "_running"}, o_running, m_mode == M_RUN);
    check({tag, "_paused"}, o_paused, m_mode == M_PAUSED);
    check({tag, "_over"}, o_game_over, m_mode == M_OVER);
    check({tag, "_overrun"}, o_overrun, m_overrun);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_step_req"}, o_step_req, 0);
    check({tag, "_grow"}, o_grow, 0);
    check({tag, "_score"}, o_score, 0);
    check({tag, "_dir"}, o_dir, 1);
    check({tag, "_wait"}, o_wait_cycles, INIT_WAIT);
    check({tag, "_flags"}, {o_running, o_paused, o_game_over, o_overrun}, 0);
  endtask

  // Monitor: every pulse the DUT presents must match the oldest prediction.
  always @(negedge i_clock) begin
    if (!i_reset) begin
      if (o_step_req) begin
        if (step_q.size() == 0) check("step_unexpected", 1, 0);
        else begin
          mon_s = step_q.pop_front();
          check("step_dir", o_dir, mon_s.dir);
          check("step_cycle", cyc, mon_s.cyc);
        end
      end
      if (o_grow) begin
        if (grow_q.size() == 0) check("grow_unexpected", 1, 0);
        else begin
          mon_g = grow_q.pop_front();
          check("grow_score", o_score, mon_g.score);
          check("grow_cycle", cyc, mon_g.cyc);
        end
      end
    end
  end

  initial begin
    i_reset = 1'b1;
    {i_tick, i_start, i_pause, i_dir_valid, i_step_done, i_collision, i_food_hit} = '0;
    i_dir = 2'd0;
    rand_dirs = 1'b0;
    model_reset();
    repeat (3) @(posedge i_clock);
    #1;
    check_reset_values("reset");
    @(posedge i_clock);
    #1 i_reset = 1'b0;
    check_output("idle");

    $display("[TB] basic steps");
    start_game();
    do_step(0, 0, 0, 0, 0, 0);
    do_step(0, 0, 0, 0, 0, 1);
    do_step(0, 0, 0, 0, 0, 2);
    check_output("basic");

    $display("[TB] direction filter");
    apply_stimulus(0, 0, 0, 0, 0, 0, 1, 2'd3);
    apply_stimulus(0, 0, 0, 0, 0, 0, 1, 2'd0);
    do_step(0, 0, 0, 0, 0, 1);
    check_output("dir_turn");
    apply_stimulus(0, 0, 0, 0, 0, 0, 1, 2'd2);
    do_step(0, 0, 0, 0, 0, 0);
    check_output("dir_reverse");

    $display("[TB] food and speed");
    for (int i = 0; i < 14; i++) begin
      do_step(1, 0, 0, 0, 0, i % 3);
      check_output("food");
    end
    while (m_score < 255) do_step(1, 0, 0, 0, 0, 0);
    check_output("sat_reach");
    do_step(1, 0, 0, 0, 0, 1);
    check_output("sat_hold");

    $display("[TB] collision");
    do_step(1, 1, 0, 0, 0, 1);
    check_output("over");
    repeat (3) apply_stimulus(1, 0, 0, 0, 0, 0);
    check_output("over_ticks");
    start_game();
    check_output("restart");

    $display("[TB] pause");
    do_step(0, 0, 1, 0, 0, 2);
    check_output("pause_deferred");
    repeat (3) apply_stimulus(1, 0, 0, 0, 0, 0);
    check_output("paused_ticks");
    toggle_pause(0);
    check_output("unpause");
    do_step(0, 0, 0, 0, 0, 0);
    toggle_pause(1);
    check_output("pause_beats_tick");
    toggle_pause(0);

    $display("[TB] overrun and reset mid-step");
    do_step(0, 0, 0, 1, 0, 2);
    check_output("overrun");
    apply_stimulus(1, 0, 0, 0, 0, 0);
    step_q.push_back('{m_pend, cyc + 2});
    apply_stimulus(0, 0, 0, 0, 0, 0);
    @(posedge i_clock);
    #1 i_reset = 1'b1;
    void'(step_q.pop_back());
    model_reset();
    #1;
    check_reset_values("mid_reset");
    @(posedge i_clock);
    #1 i_reset = 1'b0;
    check_output("after_reset");

    $display("[TB] random play");
    rand_dirs = 1'b1;
    start_game();
    for (int it = 0; it < 200; it++) begin
      case (m_mode)
        M_RUN: begin
          if ($urandom_range(0, 9) < 8)
            do_step($urandom_range(0, 1) == 1, $urandom_range(0, 11) == 0,
                    $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
                    $urandom_range(0, 9) == 0, int'($urandom_range(0, 3)));
          else toggle_pause($urandom_range(0, 1) == 1);
        end
        M_PAUSED: begin
          if ($urandom_range(0, 1) == 0) apply_stimulus(1, 0, 0, 0, 0, 0);
          else toggle_pause($urandom_range(0, 1) == 1);
        end
        default: begin
          apply_stimulus(1, 0, 0, 0, 0, 0);
          start_game();
        end
      endcase
      if (it % 10 == 9) check_output("random");
    end
    rand_dirs = 1'b0;
    check_output("final");
    idle(2);
    check("step_q_left", step_q.size(), 0);
    check("grow_q_left", grow_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
